seg_scan_driver: RTL

- Sits directly downstream of the CPU IO block's 24-bit seven-segment output and its blink flag; drives the board's 8-digit multiplexed seven-segment display.
- Converts the 24-bit binary value to 8 BCD digits with a sequential shift-add-3 converter, then time-multiplexes the digits onto shared segment lines.
- Blanks all digits at a fixed rate while blink is asserted.

---
 rtl/seg_scan_driver_if.sv | 12 +
 rtl/seg_scan_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Display-side signal bundle for seg_scan_driver: value/blink in, digit enables,
// segment code and converter busy flag out.
interface seg_scan_driver_if;
  logic [23:0] seg_value;
  logic        blink;
  logic [7:0]  seg_an;
  logic [7:0]  seg_code;
  logic        conv_busy;

  modport master (output seg_value, blink, input seg_an, seg_code, conv_busy);
  modport slave  (input seg_value, blink, output seg_an, seg_code, conv_busy);
endinterface

// File: rtl/seg_scan_driver.sv
// 24-bit binary to 8-digit BCD (shift-add-3) with multiplexed seven-segment scan and blink.
// Optional leading-zero blanking when SEG_LZ_BLANK_EN is defined.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input logic              clk,
  input logic              rst,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  state_t               state_q, state_d;
  logic [23:0]          val_q, val_d;
  logic [23:0]          cap_q, cap_d;
  logic [55:0]          sr_q, sr_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [31:0]          disp_q, disp_d;
  logic [SCAN_W-1:0]    scan_q, scan_d;
  logic [2:0]           dig_q, dig_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_off_q, blink_off_d;
  logic [7:0]           seg_an_q, seg_an_d;
  logic [7:0]           seg_code_q, seg_code_d;
  logic [55:0]          adj;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Input is registered first, so a new value sampled at edge N raises busy at N+1.
  always_comb begin
    state_d = state_q;
    val_d   = bus.seg_value;
    cap_d   = cap_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    disp_d  = disp_q;
    adj     = sr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (val_q != cap_q) begin
          cap_d   = val_q;
          sr_d    = {32'd0, val_q};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        for (int unsigned i = 0; i < 8; i++) begin
          if (adj[24 + 4*i +: 4] >= 4'd5) adj[24 + 4*i +: 4] = adj[24 + 4*i +: 4] + 4'd3;
        end
        sr_d  = {adj[54:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = ST_DONE;
      end
      ST_DONE: begin
        disp_d  = sr_q[55:24];
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SEG_LZ_BLANK_EN
  logic [7:0] lz_show;
  logic       lz_any;
  always_comb begin
    lz_any  = 1'b0;
    lz_show = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      lz_any           = lz_any | (disp_q[4*(7-k) +: 4] != 4'd0);
      lz_show[7-k]     = lz_any;
    end
    lz_show[0] = 1'b1;
  end
`endif

  // seg_an and seg_code are both derived from dig_q in the same cycle.
  always_comb begin
    scan_d      = (scan_q == SCAN_W'(SCAN_DIV - 1)) ? '0 : scan_q + SCAN_W'(1);
    dig_d       = (scan_q == SCAN_W'(SCAN_DIV - 1)) ? dig_q + 3'd1 : dig_q;
    blink_cnt_d = '0;
    blink_off_d = 1'b0;
    if (bus.blink) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_off_d = blink_off_q;
      end
    end
    seg_an_d   = ~(8'd1 << dig_q);
    seg_code_d = seg_decode(disp_q[4*dig_q +: 4]);
`ifdef SEG_LZ_BLANK_EN
    if (!lz_show[dig_q]) seg_an_d = '1;
`endif
    if (bus.blink && blink_off_q) seg_an_d = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      val_q       <= '0;
      cap_q       <= '0;
      sr_q        <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      disp_q      <= '0;
      scan_q      <= '0;
      dig_q       <= '0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
      seg_an_q    <= '1;
      seg_code_q  <= '1;
    end else begin
      state_q     <= state_d;
      val_q       <= val_d;
      cap_q       <= cap_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      disp_q      <= disp_d;
      scan_q      <= scan_d;
      dig_q       <= dig_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
      seg_an_q    <= seg_an_d;
      seg_code_q  <= seg_code_d;
    end
  end

  assign bus.seg_an    = seg_an_q;
  assign bus.seg_code  = seg_code_q;
  assign bus.conv_busy = busy_q;

endmodule
